btb_ctrl: RTL and testbench

Branch-target-buffer controller between fetch and execute. It owns the single index/update port of the BTB target memory and keeps per-entry valid, tag and 2-bit direction counters, so fetch gets taken/not-taken predictions with hit detection. Execute pushes resolved branches into a small update FIFO, which the controller arbitrates against fetch lookups. It also sequences a full-table clear after reset and on flush.

---
 rtl/btb_pkg.sv | 33 +++
 rtl/btb_upd_fifo.sv | 68 ++++++
 rtl/btb_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_btb_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btb_pkg: shared types and constants for the BTB controller            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package btb_pkg;

    localparam int PC_W = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } btb_upd_t;

    localparam logic [1:0] WEAK_NT = 2'b01;
    localparam logic [1:0] WEAK_T  = 2'b10;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btb_upd_fifo: small synchronous FIFO for resolved-branch updates      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int  UPD_DEPTH = 4,
    parameter type ENTRY_T   = btb_upd_t
) (
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   clr_in,
    input  logic   push_in,
    input  ENTRY_T push_data_in,
    input  logic   pop_in,
    output ENTRY_T head_out,
    output logic   empty_out,
    output logic   full_out
);

    localparam int AW = $clog2(UPD_DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    ENTRY_T      mem_q [UPD_DEPTH];
    ENTRY_T      mem_d [UPD_DEPTH];

    assign empty_out = (wr_q == rd_q);
    assign full_out  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_out  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (clr_in) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_in && !full_out) begin
                mem_d[wr_q[AW-1:0]] = push_data_in;
                wr_d                = wr_q + (AW+1)'(1);
            end
            if (pop_in && !empty_out) begin
                rd_d = rd_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Payload storage needs no reset: pointers gate every read.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/btb_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btb_ctrl: BTB index/update port owner, direction predictor, clear walk |
// | Optional statistics counters: define BTB_CTRL_STATS_EN                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int TAG       = 27,
    parameter int PC        = 32,
    parameter int UPD_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              fetch_req_in,
    input  logic [PC-1:0]     fetch_pc_in,
    output logic              pred_valid_out,
    output logic              pred_taken_out,
    output logic [PC-1:0]     pred_pc_out,
    input  logic              upd_valid_in,
    output logic              upd_ready_out,
    input  logic [PC-1:0]     upd_pc_in,
    input  logic [PC-1:0]     upd_target_in,
    input  logic              upd_taken_in,
    input  logic              flush_in,
    output logic              busy_out,
    output logic [PC-TAG-1:0] btb_index_out,
    output logic              btb_update_out,
    output logic [PC-1:0]     btb_new_pc_out,
    input  logic [PC-1:0]     btb_pc_in
`ifdef BTB_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_lookups_out,
    output logic [31:0]       stat_hits_out
`endif
);

    localparam int IW      = PC - TAG;
    localparam int TW      = TAG - 2;
    localparam int ENTRIES = 1 << IW;

    btb_state_e          state_q, state_d;
    logic [IW-1:0]       walk_q, walk_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TW-1:0]       tag_q [ENTRIES];
    logic [TW-1:0]       tag_d [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];
    logic [1:0]          ctr_d [ENTRIES];

    logic      run, fifo_clr, fifo_push, fifo_empty, fifo_full;
    logic      drain_gnt, fetch_gnt, f_hit, u_hit, f_taken;
    btb_upd_t  push_data, head;
    logic [IW-1:0] f_idx, u_idx;
    logic [TW-1:0] f_tag, u_tag;
    logic      unused_pc_lsbs;

    assign run   = (state_q == RUN);
    assign f_idx = fetch_pc_in[IW+1:2];
    assign f_tag = fetch_pc_in[PC-1:IW+2];
    assign u_idx = head.pc[IW+1:2];
    assign u_tag = head.pc[PC-1:IW+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign f_taken = f_hit && ctr_q[f_idx][1];
    assign unused_pc_lsbs = ^head.pc[1:0];

    // A flush cycle suppresses the drain: its write would be wiped anyway.
    assign drain_gnt = run && !flush_in && !fifo_empty && (fifo_full || !fetch_req_in);
    assign fetch_gnt = run && fetch_req_in && !drain_gnt;

    assign upd_ready_out = run && !fifo_full;
    assign fifo_push     = upd_valid_in && upd_ready_out;
    assign busy_out      = !run;
    assign push_data     = '{pc: upd_pc_in, target: upd_target_in, taken: upd_taken_in};

    btb_upd_fifo #(
        .UPD_DEPTH (UPD_DEPTH),
        .ENTRY_T   (btb_upd_t)
    ) u_upd_fifo (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .clr_in       (fifo_clr),
        .push_in      (fifo_push),
        .push_data_in (push_data),
        .pop_in       (drain_gnt),
        .head_out     (head),
        .empty_out    (fifo_empty),
        .full_out     (fifo_full)
    );

    always_comb begin
        state_d  = state_q;
        walk_d   = walk_q;
        fifo_clr = 1'b0;
        if (!run) begin
            walk_d = walk_q + IW'(1);
            if (walk_q == IW'(ENTRIES - 1)) begin
                state_d = RUN;
            end
        end else if (flush_in) begin
            state_d  = CLEAR;
            walk_d   = '0;
            fifo_clr = 1'b1;
        end
    end

    always_comb begin
        valid_d        = valid_q;
        tag_d          = tag_q;
        ctr_d          = ctr_q;
        btb_index_out  = '0;
        btb_update_out = 1'b0;
        btb_new_pc_out = '0;
        pred_valid_out = 1'b0;
        pred_taken_out = 1'b0;
        pred_pc_out    = '0;
        if (!run) begin
            btb_index_out  = walk_q;
            // Held low while reset is asserted so the BTB sees no write.
            btb_update_out = rst_n_in;
            valid_d[walk_q] = 1'b0;
            ctr_d[walk_q]   = WEAK_NT;
        end else if (drain_gnt) begin
            btb_index_out = u_idx;
            if (u_hit) begin
                ctr_d[u_idx] = ctr_step(ctr_q[u_idx], head.taken);
                if (head.taken) begin
                    btb_update_out = 1'b1;
                    btb_new_pc_out = head.target;
                end
            end else if (head.taken) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                ctr_d[u_idx]   = WEAK_T;
                btb_update_out = 1'b1;
                btb_new_pc_out = head.target;
            end
        end else if (fetch_gnt) begin
            btb_index_out  = f_idx;
            pred_valid_out = 1'b1;
            pred_taken_out = f_taken;
            pred_pc_out    = f_taken ? btb_pc_in : fetch_pc_in + PC'(4);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= CLEAR;
            walk_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= WEAK_NT;
            end
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef BTB_CTRL_STATS_EN
    logic [31:0] lookups_q, lookups_d, hits_q, hits_d;

    always_comb begin
        lookups_d = lookups_q + {31'd0, fetch_gnt};
        hits_d    = hits_q + {31'd0, fetch_gnt && f_hit};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign stat_lookups_out = lookups_q;
    assign stat_hits_out    = hits_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_btb_ctrl: directed + random bench with a table/queue reference     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_btb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, upd_valid, upd_taken, flush;
    logic [31:0] fetch_pc, upd_pc, upd_target;
    logic        pred_valid, pred_taken, upd_ready, busy, btb_update;
    logic [31:0] pred_pc, btb_new_pc, btb_pc;
    logic [4:0]  btb_index;
`ifdef BTB_CTRL_STATS_EN
    logic [31:0] stat_lookups, stat_hits;
`endif

    btb_ctrl dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .fetch_req_in   (fetch_req),
        .fetch_pc_in    (fetch_pc),
        .pred_valid_out (pred_valid),
        .pred_taken_out (pred_taken),
        .pred_pc_out    (pred_pc),
        .upd_valid_in   (upd_valid),
        .upd_ready_out  (upd_ready),
        .upd_pc_in      (upd_pc),
        .upd_target_in  (upd_target),
        .upd_taken_in   (upd_taken),
        .flush_in       (flush),
        .busy_out       (busy),
        .btb_index_out  (btb_index),
        .btb_update_out (btb_update),
        .btb_new_pc_out (btb_new_pc),
        .btb_pc_in      (btb_pc)
`ifdef BTB_CTRL_STATS_EN
        ,
        .stat_lookups_out (stat_lookups),
        .stat_hits_out    (stat_hits)
`endif
    );

    always #5 clk = ~clk;

    // Target memory stand-in: combinational read, write on negedge.
    logic [31:0] btb_mem [32];
    assign btb_pc = btb_mem[btb_index];
    always @(negedge clk) begin
        if (btb_update) btb_mem[btb_index] <= btb_new_pc;
    end

    // Reference model: per-index table plus a queue for pending updates.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          tk;
    } upd_s;

    upd_s        q[$];
    bit          m_valid [32];
    logic [31:0] m_tag   [32];
    int          m_ctr   [32];
    logic [31:0] m_tgt   [32];
    bit          mode_clear;
    int          walk;
    logic [31:0] m_lookups, m_hits;

    int errors = 0;
    int checks = 0;
    logic        s_pv, s_pt, s_ready, s_busy;
    logic [31:0] s_ppc;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h1f);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc >> 7;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle(input bit freq, input logic [31:0] fpc, input bit uv,
                            input logic [31:0] upc, input logic [31:0] utgt,
                            input bit utk, input bit fl);
        bit full, drain, fetch, e_upd, chk_idx, hit, tk;
        logic [31:0] e_idx, e_npc, e_ppc;
        int i;
        upd_s h;
        fetch_req = freq; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
        upd_target = utgt; upd_taken = utk; flush = fl;
        @(negedge clk); #1;
        s_pv = pred_valid; s_pt = pred_taken; s_ppc = pred_pc;
        s_ready = upd_ready; s_busy = busy;
        full = 0; drain = 0; fetch = 0; e_upd = 0; chk_idx = 0; hit = 0; tk = 0;
        e_idx = 0; e_npc = 0; e_ppc = 0; i = 0;
        if (mode_clear) begin
            e_upd = 1; e_idx = walk; chk_idx = 1;
        end else begin
            full  = (q.size() == DEPTH);
            drain = !fl && q.size() != 0 && (full || !freq);
            fetch = freq && !drain;
            if (drain) begin
                h = q[0]; i = midx(h.pc);
                hit = m_valid[i] && m_tag[i] == mtag(h.pc);
                if (h.tk) begin e_upd = 1; e_npc = h.tgt; e_idx = i; chk_idx = 1; end
            end else if (fetch) begin
                i = midx(fpc);
                hit = m_valid[i] && m_tag[i] == mtag(fpc);
                tk = hit && m_ctr[i] >= 2;
                e_ppc = tk ? m_tgt[i] : fpc + 32'd4;
                e_idx = i; chk_idx = 1;
            end
        end
        chk("busy", s_busy, mode_clear);
        chk("upd_ready", s_ready, !mode_clear && !full);
        chk("pred_valid", s_pv, fetch);
        chk("pred_taken", s_pt, tk);
        chk("pred_pc", s_ppc, e_ppc);
        chk("btb_update", btb_update, e_upd);
        if (e_upd) chk("btb_new_pc", btb_new_pc, e_npc);
        if (chk_idx) chk("btb_index", btb_index, e_idx);
`ifdef BTB_CTRL_STATS_EN
        chk("stat_lookups", stat_lookups, m_lookups);
        chk("stat_hits", stat_hits, m_hits);
`endif
        if (fetch) m_lookups++;
        if (fetch && hit) m_hits++;
        if (mode_clear) begin
            m_valid[walk] = 0; m_ctr[walk] = 1; walk++;
            if (walk == 32) mode_clear = 0;
        end else begin
            if (drain) begin
                void'(q.pop_front());
                if (hit) begin
                    m_ctr[i] = h.tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                    if (h.tk) m_tgt[i] = h.tgt;
                end else if (h.tk) begin
                    m_valid[i] = 1; m_tag[i] = mtag(h.pc); m_ctr[i] = 2; m_tgt[i] = h.tgt;
                end
            end
            if (uv && !full) q.push_back('{pc: upc, tgt: utgt, tk: utk});
            if (fl) begin mode_clear = 1; walk = 0; q.delete(); end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        do_cycle(0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lk0, ht0, rpc;
        for (int k = 0; k < 32; k++) begin
            btb_mem[k] = 32'hdead_0000; m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = 0;
        end
        m_lookups = 0; m_hits = 0;
        rst_n = 0; fetch_req = 1; fetch_pc = 32'h100; upd_valid = 0; upd_pc = 0;
        upd_target = 0; upd_taken = 0; flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", busy, 1);
        chk("rst_ready", upd_ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_pc", pred_pc, 0);
        chk("rst_btb_update", btb_update, 0);
        chk("rst_btb_index", btb_index, 0);
        @(posedge clk); #1;
        rst_n = 1;
        mode_clear = 1; walk = 0;

        // Clear walk after reset, then the table is usable.
        repeat (32) idle();
        idle();
        chk("walk_done_ready", s_ready, 1);
        chk("walk_done_busy", s_busy, 0);

        // Allocate 0x100 -> 0x400, then predict it.
        do_cycle(0, 32'h0, 1, 32'h100, 32'h400, 1, 0);
        idle();
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        chk("alloc_taken", s_pt, 1);
        chk("alloc_target", s_ppc, 32'h400);

        // Three not-taken updates walk the counter down to strong not-taken.
        repeat (3) do_cycle(0, 32'h0, 1, 32'h100, 32'h0, 0, 0);
        idle();
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        chk("nt_taken", s_pt, 0);
        chk("nt_fallthrough", s_ppc, 32'h104);

        // Fill with fetch held high; a full FIFO forces a drain.
        for (int k = 0; k < 4; k++)
            do_cycle(1, 32'h100, 1, 32'h200 + 32'(k * 4), 32'h800 + 32'(k * 16), 1, 0);
        do_cycle(1, 32'h100, 1, 32'h240, 32'h900, 1, 0);
        chk("full_pred_blocked", s_pv, 0);
        chk("full_not_ready", s_ready, 0);
        repeat (4) idle();

        // Flush with two queued updates: discarded, walk, then 0x100 misses.
        do_cycle(1, 32'h100, 1, 32'h300, 32'h500, 1, 0);
        do_cycle(1, 32'h100, 1, 32'h304, 32'h504, 1, 0);
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 1);
        repeat (32) do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        idle();
        chk("post_flush_no_write", btb_update, 0);
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        chk("post_flush_miss", s_pt, 0);
        chk("post_flush_pc", s_ppc, 32'h104);

        // Five lookups, two of them hits.
        lk0 = m_lookups; ht0 = m_hits;
        do_cycle(0, 32'h0, 1, 32'h100, 32'h440, 1, 0);
        idle();
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        do_cycle(1, 32'h104, 0, 32'h0, 32'h0, 0, 0);
        do_cycle(1, 32'h100, 0, 32'h0, 32'h0, 0, 0);
        do_cycle(1, 32'h108, 0, 32'h0, 32'h0, 0, 0);
        do_cycle(1, 32'h180, 0, 32'h0, 32'h0, 0, 0);
        chk("aliased_tag_miss", s_pt, 0);
        chk("model_lookups5", m_lookups - lk0, 5);
        chk("model_hits2", m_hits - ht0, 2);
`ifdef BTB_CTRL_STATS_EN
        idle();
        chk("stat_lookups_total", stat_lookups, lk0 + 5);
        chk("stat_hits_total", stat_hits, ht0 + 2);
`endif

        // Random traffic over a small aliased PC pool.
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 1) != 0 ? 32'h1080 : 32'h1000) + 32'($urandom_range(0, 7) << 2);
            do_cycle($urandom_range(0, 9) < 7, rpc,
                     $urandom_range(0, 1) != 0,
                     ($urandom_range(0, 1) != 0 ? 32'h1080 : 32'h1000) + 32'($urandom_range(0, 7) << 2),
                     $urandom & 32'hffff_fffc,
                     $urandom_range(0, 2) != 0,
                     $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
